// File: rtl/pipes_scroller_if.sv
// Bundles the pipe scroller's run controls and board/score outputs.
// The game tick logic holds the master side. The scroller holds the slave side.
interface pipes_scroller_if #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int SCORE_W = 8
);
  logic                       en_i;
  logic                       clear_i;
  logic [ROWS-1:0][COLS-1:0]  shiftedGreen_o;
  logic                       step_o;
  logic                       passPulse_o;
  logic [SCORE_W-1:0]         score_o;

  modport master (
    output en_i, clear_i,
    input  shiftedGreen_o, step_o, passPulse_o, score_o
  );

  modport slave (
    input  en_i, clear_i,
    output shiftedGreen_o, step_o, passPulse_o, score_o
  );
endinterface

// File: rtl/pipes_scroller.sv
// Flappy-bird obstacle field generator.
// The board scrolls one column left on every STEP_CYCLES enabled clocks.
// A pipe enters at the right edge every PIPE_W+SPACING steps. Each pipe has an
// LFSR-chosen gap. The block keeps a saturating count of pipes that have fully
// cleared the bird column.
module pipes_scroller #(
  parameter int          ROWS        = 16,
  parameter int          COLS        = 16,
  parameter int          GAP         = 4,
  parameter int          PIPE_W      = 2,
  parameter int          SPACING     = 5,
  parameter int          STEP_CYCLES = 4,
  parameter int          BIRD_COL    = 3,
  parameter int          SCORE_W     = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic               clk_i,
  input logic               rst_ni,
  pipes_scroller_if.slave   bus
);

  localparam int          P       = PIPE_W + SPACING;
  localparam int          DIV_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int          CNT_W   = $clog2(P);
  localparam int          GW      = $clog2(ROWS);
  localparam logic [15:0] GAP_MOD = 16'(ROWS - GAP - 1);

  logic [ROWS-1:0][COLS-1:0] board_q, board_d;
  logic [COLS-1:0]           pipeCol_q, pipeCol_d;
  logic [DIV_W-1:0]          divCnt_q;
  logic [CNT_W-1:0]          colCnt_q;
  logic [GW-1:0]             gapTop_q;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [SCORE_W-1:0]        score_q;
  logic                      step_q, passPulse_q;

  logic                      stepNow, pipeStart, spawnBit, passed;
  logic [GW-1:0]             freshGap, gapUse;
  logic [ROWS-1:0]           spawnCol;

  // Work out the column entering at the right edge and what the board, occupancy and LFSR become if this edge steps
  always_comb begin
    stepNow   = bus.en_i && (divCnt_q == DIV_W'(STEP_CYCLES - 1));
    pipeStart = (colCnt_q == '0);
    freshGap  = GW'(lfsr_q % GAP_MOD) + GW'(1);
    gapUse    = pipeStart ? freshGap : gapTop_q;
    spawnBit  = (colCnt_q < CNT_W'(PIPE_W));
    spawnCol  = '0;
    for (int r = 0; r < ROWS; r++) begin
      spawnCol[r] = spawnBit &&
                    !((GW'(r) >= gapUse) && (GW'(r) <= gapUse + GW'(GAP - 1)));
    end
    lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    pipeCol_d = {spawnBit, pipeCol_q[COLS-1:1]};
    board_d   = '0;
    for (int r = 0; r < ROWS; r++) begin
      board_d[r] = {spawnCol[r], board_q[r][COLS-1:1]};
    end
    passed    = pipeCol_q[BIRD_COL] && !pipeCol_d[BIRD_COL];
  end

  // Scroll, spawn and score. Clear beats a pending step. The LFSR and the latched gap survive a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      board_q     <= '0;
      pipeCol_q   <= '0;
      divCnt_q    <= '0;
      colCnt_q    <= '0;
      gapTop_q    <= '0;
      lfsr_q      <= SEED;
      score_q     <= '0;
      step_q      <= 1'b0;
      passPulse_q <= 1'b0;
    end else if (bus.clear_i) begin
      board_q     <= '0;
      pipeCol_q   <= '0;
      divCnt_q    <= '0;
      colCnt_q    <= '0;
      score_q     <= '0;
      step_q      <= 1'b0;
      passPulse_q <= 1'b0;
    end else if (bus.en_i) begin
      step_q      <= stepNow;
      passPulse_q <= stepNow && passed;
      if (stepNow) begin
        divCnt_q  <= '0;
        board_q   <= board_d;
        pipeCol_q <= pipeCol_d;
        colCnt_q  <= (colCnt_q == CNT_W'(P - 1)) ? '0 : colCnt_q + CNT_W'(1);
        if (pipeStart) begin
          gapTop_q <= freshGap;
          lfsr_q   <= lfsr_d;
        end
        if (passed && (score_q != {SCORE_W{1'b1}})) begin
          score_q <= score_q + SCORE_W'(1);
        end
      end else begin
        divCnt_q <= divCnt_q + DIV_W'(1);
      end
    end else begin
      step_q      <= 1'b0;
      passPulse_q <= 1'b0;
    end
  end

  assign bus.shiftedGreen_o = board_q;
  assign bus.step_o         = step_q;
  assign bus.passPulse_o    = passPulse_q;
  assign bus.score_o        = score_q;

endmodule

// File: tb/tb_pipes_scroller.sv
// Bench for pipes_scroller. It runs two instances side by side: one has the default score
// width, and the other has a 2-bit score that shows saturation.
// The reference model does not copy the register pipeline. It counts enabled clocks since the
// last clear or reset. From that count it derives the number of steps taken. It then rebuilds
// each board column from the step index that emitted it.
module tb_pipes_scroller;

  localparam int          ROWS        = 16;
  localparam int          COLS        = 16;
  localparam int          GAP         = 4;
  localparam int          PIPE_W      = 2;
  localparam int          SPACING     = 5;
  localparam int          STEP_CYCLES = 4;
  localparam int          BIRD_COL    = 3;
  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          P           = PIPE_W + SPACING;
  localparam int          PASS_OFF    = PIPE_W + COLS - BIRD_COL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  pipes_scroller_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(8)) busA ();
  pipes_scroller_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(2)) busB ();

  pipes_scroller #(
    .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .PIPE_W(PIPE_W), .SPACING(SPACING),
    .STEP_CYCLES(STEP_CYCLES), .BIRD_COL(BIRD_COL), .SCORE_W(8), .SEED(SEED)
  ) dutA (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (busA)
  );

  pipes_scroller #(
    .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .PIPE_W(PIPE_W), .SPACING(SPACING),
    .STEP_CYCLES(STEP_CYCLES), .BIRD_COL(BIRD_COL), .SCORE_W(2), .SEED(SEED)
  ) dutB (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (busB)
  );

  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;
  int          enCount    = 0;
  logic [15:0] baseLfsr   = SEED;
  bit          expStep    = 1'b0;

  function automatic logic [15:0] lfsrNext(logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int gapOf(int pipeIdx);
    logic [15:0] v = baseLfsr;
    for (int i = 0; i < pipeIdx; i++) v = lfsrNext(v);
    return int'(v % 16'(ROWS - GAP - 1)) + 1;
  endfunction

  function automatic int passesBy(int n);
    return (n >= PASS_OFF) ? ((n - PASS_OFF) / P + 1) : 0;
  endfunction

  function automatic logic [ROWS-1:0][COLS-1:0] expBoard(int n);
    logic [ROWS-1:0][COLS-1:0] b = '0;
    for (int c = 0; c < COLS; c++) begin
      int j = n - (COLS - 1 - c);
      if (j >= 1 && ((j - 1) % P) < PIPE_W) begin
        int g = gapOf((j - 1) / P);
        for (int r = 0; r < ROWS; r++) b[r][c] = (r < g) || (r > g + GAP - 1);
      end
    end
    return b;
  endfunction

  function automatic logic [ROWS-1:0] column(logic [ROWS-1:0][COLS-1:0] b, int c);
    logic [ROWS-1:0] v = '0;
    for (int r = 0; r < ROWS; r++) v[r] = b[r][c];
    return v;
  endfunction

  task automatic checkOutput(string tag, logic [ROWS*COLS-1:0] obs, logic [ROWS*COLS-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the model's current state
  task automatic checkAll();
    int n       = enCount / STEP_CYCLES;
    bit expPass = expStep && (n >= PASS_OFF) && (((n - PASS_OFF) % P) == 0);
    int sc      = passesBy(n);
    checkOutput("board",  busA.shiftedGreen_o, expBoard(n));
    checkOutput("step",   busA.step_o, expStep);
    checkOutput("pass",   busA.passPulse_o, expPass);
    checkOutput("score",  busA.score_o, (sc > 255) ? 255 : sc);
    checkOutput("passB",  busB.passPulse_o, expPass);
    checkOutput("scoreB", busB.score_o, (sc > 3) ? 3 : sc);
  endtask

  // Drive one clock edge of inputs, advance the model, then check just after the edge
  task automatic applyStimulus(bit enVal, bit clearVal);
    busA.en_i = enVal;  busA.clear_i = clearVal;
    busB.en_i = enVal;  busB.clear_i = clearVal;
    @(posedge clk);
    if (clearVal) begin
      int n = enCount / STEP_CYCLES;
      for (int i = 0; i < (n + P - 1) / P; i++) baseLfsr = lfsrNext(baseLfsr);
      enCount = 0;
      expStep = 1'b0;
    end else if (enVal) begin
      enCount++;
      expStep = (enCount % STEP_CYCLES) == 0;
    end else begin
      expStep = 1'b0;
    end
    #1;
    checkAll();
  endtask

  // Pull reset between edges, confirm the outputs clear at once, release on the falling edge
  task automatic midCycleReset();
    #2;
    rst_n = 1'b0;
    #1;
    enCount  = 0;
    baseLfsr = SEED;
    expStep  = 1'b0;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    busA.en_i = 1'b0;  busA.clear_i = 1'b0;
    busB.en_i = 1'b0;  busB.clear_i = 1'b0;
    @(posedge clk);
    #2;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    for (int e = 1; e <= 172; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (e == 4) begin
        checkOutput("firstStepPulse", busA.step_o, 1'b1);
        checkOutput("firstPipeCol15", column(busA.shiftedGreen_o, 15), 16'hFE1F);
        checkOutput("firstPipeCol14", column(busA.shiftedGreen_o, 14), 16'h0000);
      end
      if (e == 60) begin
        checkOutput("firstPassPulse", busA.passPulse_o, 1'b1);
        checkOutput("firstPassScore", busA.score_o, 8'd1);
      end
      if (e == 88) checkOutput("secondPassScore", busA.score_o, 8'd2);
      if (e == 172) begin
        checkOutput("fifthPassScore", busA.score_o, 8'd5);
        checkOutput("saturatedScoreB", busB.score_o, 2'd3);
        checkOutput("saturatedPassB", busB.passPulse_o, 1'b1);
      end
    end

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0);

    while (((enCount + 1) % STEP_CYCLES) != 0) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clearOnStepStep", busA.step_o, 1'b0);
    checkOutput("clearOnStepScore", busA.score_o, 8'd0);
    checkOutput("clearOnStepBoard", busA.shiftedGreen_o, '0);
    for (int i = 0; i < 4 * 2 * P; i++) applyStimulus(1'b1, 1'b0);

    midCycleReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);

    for (int i = 0; i < 700; i++) begin
      int pick = $urandom_range(0, 299);
      if (pick == 0) midCycleReset();
      else applyStimulus($urandom_range(0, 3) != 0, pick < 3);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipes_scroller.md
Name: pipes_scroller

Overview:
Parametrised successor to the fixed 16x16 pipe scroller. It generates the flappy-bird obstacle field on a ROWS x COLS board and scrolls it one column left per game step. Each pipe gets an LFSR-chosen gap, and the block keeps a saturating pass score at the bird column. It sits between the game tick logic and the display/collision logic, which read shifted_green.

Parameters:
ROWS, 16, board height; must be >= GAP+3.
COLS, 16, board width; must be >= BIRD_COL+2.
GAP, 4, rows of open space in each pipe.
PIPE_W, 2, pipe width in columns; must be >= 1.
SPACING, 5, empty columns between pipes; must be >= 1.
STEP_CYCLES, 4, enabled clocks per scroll step; must be >= 1.
BIRD_COL, 3, column used for pass detection.
SCORE_W, 8, score width.
SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; low freezes all state
clear  in  1  synchronous board/score clear
shifted_green  out  [ROWS-1:0][COLS-1:0]  board; [r][c]=1 means pipe cell; column 0 is leftmost
step  out  1  one-cycle pulse on the edge the board moved
pass_pulse  out  1  one-cycle pulse when a pipe fully clears BIRD_COL
score  out  SCORE_W  pipes passed, saturating

Behaviour:
- Reset (rst=0), taking effect immediately:
  - shifted_green=0, score=0, step=0, pass_pulse=0.
  - Internal: div_cnt=0, col_cnt=0, pipe_col=0, gap_top=0, lfsr=SEED.
- All registered outputs update on the same edge. There is no extra output latency.
- Prescaler:
  - When en=1, div_cnt increments.
  - A step occurs on the edge where div_cnt==STEP_CYCLES-1; div_cnt then wraps to 0.
  - When en=0, nothing changes and step=0.
- Step, on that edge:
  - For c<COLS-1: board[r][c] <= board[r][c+1].
  - Column COLS-1 receives the spawn column.
  - pipe_col, a COLS-bit occupancy vector, shifts identically.
- Spawn:
  - Period P=PIPE_W+SPACING. col_cnt counts 0..P-1 per step and wraps.
  - col_cnt==0: new gap g = (lfsr mod (ROWS-GAP-1)) + 1, computed from the current lfsr. g is latched into gap_top, and lfsr advances once on this step.
  - col_cnt<PIPE_W: emit a pipe column. Row r is 1 unless g<=r<=g+GAP-1. The first column uses the fresh g; later columns use gap_top. Spawn bit is 1.
  - Otherwise: emit an all-zero column, spawn bit 0.
  - The gap never touches row 0 or row ROWS-1.
- LFSR: 16-bit Galois, right shift; if bit0 was 1, XOR with 16'hB400. It advances only at pipe starts, so the gap sequence is deterministic from SEED.
- Pass detection: on a step where the old pipe_col[BIRD_COL]==1 and the new pipe_col[BIRD_COL]==0:
  - pass_pulse=1 for that cycle.
  - score increments, holding at 2^SCORE_W-1.
- step and pass_pulse are 0 on all other cycles.
- clear=1, synchronous, has priority over step:
  - Board, pipe_col, div_cnt, col_cnt and score go to 0; pulses go to 0.
  - lfsr and gap_top are held.
  - clear acts even when en=0.
- Reset mid-step or mid-pipe: async return to reset state. The next step restarts at col_cnt=0 with gap from SEED.
- Boundary cases:
  - A pipe partially scrolled off column 0 is simply dropped.
  - A pipe still overlapping BIRD_COL at clear never scores.

Test Plan:
- Reset/first step, defaults: release rst, en=1 -> step pulses on the 4th edge. Column 15 then has rows 0-4 and 9-15 =1, rows 5-8 =0 (0xACE1 mod 11 = 4, g=5). All other columns are 0.
- Pipe width: on the 2nd step, columns 14 and 15 hold the identical pipe pattern. Steps 3-7 insert zero columns at column 15. Step 8 spawns a new pipe with g computed from the advanced lfsr.
- Scoring: a free run with en=1 gives pass_pulse exactly once, at step 15 (edge 60), and score=1. The next pass is at step 22 (score=2).
- Freeze: drop en for 10 cycles mid-run -> board, div_cnt, score and lfsr are unchanged and step=0. Resume -> timing shifts by exactly 10 cycles.
- Clear vs step: assert clear on the edge that would step -> board=0, score=0, step=0. The next pipe uses the retained lfsr, not SEED.
- Async reset and saturation: pull rst low between edges -> outputs clear before the next edge. A separate run with SCORE_W=2 and 5 passes -> score sticks at 3 while pass_pulse still fires each pass.
